// File: rtl/dm_cache_pkg.sv
// Shared types and defaults for the direct-mapped cache controller.
// Contents:
//   cache_state_t - controller FSM states
//   DEF_*         - default parameter values
//   tag_width()   - tag bits left after removing index and offset bits
package dm_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMemReq,
        StFill,
        StRespond
    } cache_state_t;

    localparam int unsigned DEF_ADDR_W   = 15;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_INDEX_W  = 10;
    localparam int unsigned DEF_OFFSET_W = 2;
    localparam int unsigned DEF_CNT_W    = 16;

    // Signed result so an impossible split shows up as a value below 1.
    function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
        return addr_w - index_w - offset_w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for cache hit/miss statistics.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset, clears the count
//   inc   - increment request for this cycle
//   count - current value, holds at all-ones instead of wrapping
module sat_counter
    import dm_cache_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller with multi-word lines and line refill.
// Ports:
//   clk, rst                       - clock, asynchronous active-low reset
//   flush                          - invalidates every line when seen in idle
//   req_valid/req_ready/req_addr   - word-address read request handshake
//   rsp_valid/rsp_data             - single-cycle read response, no backpressure
//   mem_req_valid/ready/addr       - line-aligned fill request to memory
//   mem_rsp_valid/mem_rsp_data     - fill words, ascending offset order
//   hit_count/miss_count           - saturating statistics
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned INDEX_W  = DEF_INDEX_W,
    parameter int unsigned OFFSET_W = DEF_OFFSET_W,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int          TAG_W = tag_width(ADDR_W, INDEX_W, OFFSET_W);
    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned WORDS = 1 << OFFSET_W;

    if (TAG_W < 1) begin : g_tag_w_check
        $error("dm_cache_ctrl: ADDR_W must be larger than INDEX_W + OFFSET_W");
    end

    cache_state_t state_q, state_d;

    logic [ADDR_W-1:0]   addr_q;
    logic [OFFSET_W-1:0] beat_q, beat_d;
    logic [LINES-1:0]    valid_q;

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES*WORDS];

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic [DATA_W-1:0]   line_word;
    logic                hit;
    logic                fill_we;
    logic                fill_last;
    logic                hit_inc;
    logic                miss_inc;

    assign {req_tag, req_index, req_offset} = addr_q;

    assign line_word = data_mem[{req_index, req_offset}];
    assign hit       = valid_q[req_index] && (tag_mem[req_index] == req_tag);
    assign fill_we   = (state_q == StFill) && mem_rsp_valid;
    assign fill_last = fill_we && (&beat_q);

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    rsp_valid = 1'b1;
                    rsp_data  = line_word;
                    hit_inc   = 1'b1;
                    state_d   = StIdle;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = StMemReq;
                end
            end
            StMemReq: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, {OFFSET_W{1'b0}}};
                if (mem_req_ready) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (fill_last) begin
                    state_d = StRespond;
                end
            end
            StRespond: begin
                rsp_valid = 1'b1;
                rsp_data  = line_word;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat counter wraps to zero on the last beat, ready for the next fill.
    always_comb begin
        beat_d = beat_q;
        if (fill_we) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (state_q == StIdle && req_valid && !flush) begin
                addr_q <= req_addr;
            end
        end
    end

    // A line becomes valid only once its final beat lands, so an aborted fill stays invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (state_q == StIdle && flush) begin
            valid_q <= '0;
        end else if (fill_last) begin
            valid_q[req_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{req_index, beat_q}] <= mem_rsp_data;
        end
        if (fill_last) begin
            tag_mem[req_index] <= req_tag;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_hit_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit_inc),
        .count(hit_count)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_miss_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (miss_inc),
        .count(miss_count)
    );

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: directed scenarios plus random reads, with a response scoreboard.
module tb_dm_cache_ctrl;

    localparam int unsigned ADDR_W   = 15;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned INDEX_W  = 10;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned CNT_W    = 3;
    localparam int unsigned LINES    = 1 << INDEX_W;
    localparam int unsigned WORDS    = 1 << OFFSET_W;
    localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mem_rsp_data = '0;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    dm_cache_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .INDEX_W (INDEX_W),
        .OFFSET_W(OFFSET_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: backing memory is a fixed function of the word address.
    function automatic logic [31:0] mem_word(input int unsigned a);
        return 32'hC0DE_0000 ^ (a * 32'h9E37_79B1);
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    int unsigned m_hits = 0;
    int unsigned m_miss = 0;

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_hits = 0;
        m_miss = 0;
    endtask

    // Scoreboard: expected data and latency (0 = latency not checked).
    logic [31:0] exp_data_q [$];
    int          exp_lat_q  [$];
    int unsigned acc_cyc = 0;
    int          rsp_seen = 0;

    always @(negedge clk) begin
        if (rst && rsp_valid) begin
            if (exp_data_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rsp: got %h, expected no response", rsp_data);
            end else begin
                logic [31:0] d;
                int          lat;
                d   = exp_data_q.pop_front();
                lat = exp_lat_q.pop_front();
                chk("rsp_data", rsp_data, d);
                if (lat != 0) chk("latency", 32'(cyc - acc_cyc + 1), 32'(lat));
                rsp_seen++;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, "_mem_req_addr"}, 32'(mem_req_addr), 32'd0);
        chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
        chk({tag, "_miss_count"}, 32'(miss_count), 32'd0);
    endtask

    // One read. A miss is served with `stall` cycles of ready-low and random beat gaps up to
    // maxgap. If nbeats < WORDS the fill is cut short by asserting reset.
    task automatic do_read(input int unsigned a, input int stall, input int maxgap,
                           input int nbeats);
        int unsigned tag, idx, off, line;
        bit          hit;
        bit          zero_wait;
        int          gaps [WORDS];
        int          seen0;
        int          n;
        tag  = a / (WORDS * LINES);
        idx  = (a / WORDS) % LINES;
        off  = a % WORDS;
        line = a - off;
        hit  = m_valid[idx] && (m_tag[idx] == tag);
        zero_wait = (stall == 0);
        foreach (gaps[i]) begin
            gaps[i] = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            if (gaps[i] != 0) zero_wait = 1'b0;
        end
        if (hit) begin
            m_hits = sat_inc(m_hits);
        end else begin
            m_miss     = sat_inc(m_miss);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
        end
        seen0 = rsp_seen;
        exp_data_q.push_back(mem_word(a));
        exp_lat_q.push_back(hit ? 1 : (zero_wait ? 7 : 0));

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        #1 chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        acc_cyc = cyc + 1;
        @(negedge clk);
        req_valid = 1'b0;

        if (!hit) begin
            n = 0;
            while (!mem_req_valid && n < 10) begin
                @(negedge clk);
                n++;
            end
            if (!mem_req_valid) begin
                chk("mem_req_timeout", 32'd0, 32'd1);
            end else begin
                chk("mem_req_addr", 32'(mem_req_addr), line);
                for (int s = 0; s < stall; s++) begin
                    // Stray fill data outside the fill phase must be ignored.
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = $urandom;
                    @(negedge clk);
                    chk("mem_req_valid_stall", 32'(mem_req_valid), 32'd1);
                    chk("mem_req_addr_stall", 32'(mem_req_addr), line);
                end
                mem_rsp_valid = 1'b0;
                mem_req_ready = 1'b1;
                @(negedge clk);
                mem_req_ready = 1'b0;
                for (int b = 0; b < nbeats; b++) begin
                    for (int g = 0; g < gaps[b]; g++) begin
                        mem_rsp_valid = 1'b0;
                        @(negedge clk);
                    end
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(line + int'(b));
                    @(negedge clk);
                end
                mem_rsp_valid = 1'b0;
            end
        end

        if (nbeats < int'(WORDS)) begin
            rst = 1'b0;
            #1 chk_reset_outputs("midfill");
            exp_data_q.delete();
            exp_lat_q.delete();
            model_reset();
            @(negedge clk);
            rst = 1'b1;
            return;
        end

        n = 0;
        while (rsp_seen == seen0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        if (rsp_seen == seen0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            exp_data_q.delete();
            exp_lat_q.delete();
        end
        chk("hit_count", 32'(hit_count), m_hits);
        chk("miss_count", 32'(miss_count), m_miss);
    endtask

    task automatic do_flush(input int unsigned a);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = ADDR_W'(a);
        #1 chk("req_ready_flush", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        #1 chk("req_ready_after_flush", 32'(req_ready), 32'd1);
        foreach (m_valid[i]) m_valid[i] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned a;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;

        // Cold miss at zero-wait memory, then a hit in the same line.
        do_read(32'h0005, 0, 0, WORDS);
        do_read(32'h0006, 0, 0, WORDS);
        // Conflict eviction on index 1.
        do_read(32'h0004, 0, 0, WORDS);
        do_read(32'h1004, 0, 0, WORDS);
        do_read(32'h0004, 0, 0, WORDS);
        chk("miss_count_conflict", 32'(miss_count), 32'd3);
        // Flush invalidates the filled line.
        do_read(32'h0008, 0, 0, WORDS);
        do_flush(32'h0008);
        do_read(32'h0008, 0, 0, WORDS);
        // Handshake stalls and beat gaps.
        do_read(32'h2010, 5, 0, WORDS);
        do_read(32'h3017, 0, 3, WORDS);
        do_read(32'h3016, 0, 0, WORDS);

        // Random reads over a small address pool to mix hits, misses and conflicts.
        for (int i = 0; i < 40; i++) begin
            a = $urandom_range(0, 2) * (WORDS * LINES) + $urandom_range(0, 7) * WORDS
                + $urandom_range(0, WORDS - 1);
            if ($urandom_range(0, 7) == 0) do_flush(a);
            do_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), WORDS);
        end

        // Reset after two beats aborts the fill; the same address then misses afresh.
        do_read(32'h0024, 0, 1, 2);
        do_read(32'h0025, 0, 0, WORDS);
        chk("miss_count_after_reset", 32'(miss_count), 32'd1);

        // Nine hits saturate a 3-bit counter at 7.
        for (int i = 0; i < 9; i++) begin
            do_read(32'h0024 + (i % WORDS), 0, 0, WORDS);
        end
        chk("hit_count_saturated", 32'(hit_count), 32'd7);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Parametrised, clocked direct-mapped cache controller with multi-word lines, a valid/ready request port, and a line-fill handshake to backing memory. It sits between a processor load port and the main-memory model. It adds several things to the existing single-line, combinational cache: line refill on miss, flush, and saturating hit/miss statistics.

## Interface
- `ADDR_W`, 15: word-address width.
- `DATA_W`, 32: data word width.
- `INDEX_W`, 10: line-index bits (2^INDEX_W lines).
- `OFFSET_W`, 2: word-in-line bits (2^OFFSET_W words per line).
- `CNT_W`, 16: statistics counter width.
- Derived: `TAG_W = ADDR_W - INDEX_W - OFFSET_W`. Elaboration error if `TAG_W < 1`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `flush` in 1: pulse that invalidates all lines.
- `req_valid` in 1: read request present.
- `req_ready` out 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_addr` in ADDR_W: word address.
- `rsp_valid` out 1: one-cycle pulse when read data is valid.
- `rsp_data` out DATA_W: read data.
- `mem_req_valid` out 1: line-fill request to memory.
- `mem_req_ready` in 1: memory accepts the fill request.
- `mem_req_addr` out ADDR_W: line-aligned address; low OFFSET_W bits are 0.
- `mem_rsp_valid` in 1: one fill word per asserted cycle.
- `mem_rsp_data` in DATA_W: fill word, delivered in ascending offset order.
- `hit_count` out CNT_W: saturating hit counter.
- `miss_count` out CNT_W: saturating miss counter.

## Operation
- Address split: `{tag, index, offset}`, MSB to LSB.
- Storage per line: valid bit, TAG_W tag, 2^OFFSET_W data words.
- FSM states: IDLE, LOOKUP, MEM_REQ, FILL, RESPOND.
- **IDLE**
  - `req_ready = !flush`.
  - On accept: latch `req_addr`, go to LOOKUP.
  - `flush` high: clear every valid bit this edge and accept nothing. Data and tags are untouched.
- **LOOKUP**
  - Hit when `valid[index] && tag[index] == tag`.
  - Hit: `rsp_valid = 1`, `rsp_data = line[index][offset]`, `hit_count++`, go to IDLE.
  - Miss: `miss_count++`, go to MEM_REQ.
- **MEM_REQ**
  - `mem_req_valid = 1` with `mem_req_addr = {tag, index, 0}`, held stable until `mem_req_ready`, then go to FILL.
- **FILL**
  - Beat counter runs 0 to 2^OFFSET_W−1.
  - Each `mem_rsp_valid` writes `line[index][beat]`.
  - On the last beat: write tag, set valid, go to RESPOND.
- **RESPOND**
  - `rsp_valid = 1`, `rsp_data = line[index][offset]` (the freshly filled word), go to IDLE.
- `mem_rsp_valid` outside FILL is ignored.
- `flush` outside IDLE is ignored; it is not queued.
- Counters stop at 2^CNT_W−1 and do not wrap.
- A miss always replaces the indexed line. There is no write-back; the cache is read-only.

## Timing
- **Reset:**
  - State goes to IDLE; all valid bits, counters and the beat counter go to 0.
  - Outputs: `req_ready = 1`, `rsp_valid = 0`, `rsp_data = 0`, `mem_req_valid = 0`, `mem_req_addr = 0`.
  - Reset asserted mid-fill aborts the fill. The partially filled line stays invalid.
- **Hit latency:** accept at edge N, `rsp_valid` during cycle N+1.
- **Miss latency:** 1 + (request wait ≥1) + (2^OFFSET_W beats, gaps allowed) + 1 cycles. With zero-wait memory and OFFSET_W=2: response 7 cycles after accept.
- **Throughput:** one outstanding request. `req_ready` is low in all states except IDLE.
- `rsp_valid` has no backpressure; the consumer must sample it.
- Tags and data are registered storage. The LOOKUP comparison is combinational within that cycle.

## Structure
- Package `dm_cache_pkg` holds:
  - the state enum `cache_state_t` (IDLE, LOOKUP, MEM_REQ, FILL, RESPOND);
  - default parameter constants;
  - the TAG_W derivation function.
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `rst`, `inc`, `count`), instantiated twice for the hit and miss counters.

## Test plan
- **Cold miss then hit:**
  - After reset, read 0x0005. Expect `mem_req_addr` = 0x0004, 4 beats A0..A3 fed, `rsp_data` = A1, `miss_count` = 1.
  - Then read 0x0006. Expect hit with `rsp_data` = A2 one cycle after accept, `hit_count` = 1.
- **Conflict eviction:** fill 0x0004, then read 0x1004 (same index, different tag). Expect a miss and refill; a re-read of 0x0004 misses again, so `miss_count` = 3.
- **Flush:** fill 0x0008, pulse `flush` in IDLE with `req_valid` high. Expect `req_ready` = 0 that cycle; the next read of 0x0008 misses.
- **Handshake stalls:**
  - Hold `mem_req_ready` low for 5 cycles. Expect `mem_req_valid` and `mem_req_addr` stable throughout.
  - Insert gaps between `mem_rsp_valid` beats. Expect the correct word order is still kept.
- **Reset mid-fill:** assert `rst` low after beat 2. Expect all outputs at reset values; the same address then misses and `miss_count` restarts from 1.
- **Saturation:** with CNT_W=3, perform 9 hits. Expect `hit_count` = 7.
